// File: rtl/phase_seq.sv
// ---------------------------------------------------------------------------
// phase_seq: instruction-phase sequencer for the multi-cycle CPU.
//
// Steps the core through Fetch, Execute, Memory and Writeback phases. It adds:
//   - memory wait-states in the F and M phases (MEMWS minimum extra cycles,
//     further stretched while mem_ready is low),
//   - run/halt control,
//   - single-step driven by the rising edge of step,
//   - a retired-instruction counter.
//
// Parameters:
//   MEMWS      minimum extra wait cycles in F and M (0..15)
//   CNTW       width of the retired-instruction counter
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous active-high reset
//   run        level, 1 = free-running execution
//   step       single-step request (rising edge detected internally)
//   mem_ready  memory bus ready, qualifies completion of F and M
//   phf..phwb  one-hot phase strobes (registered), all 0 while halted
//   en         phase-complete strobe (combinational), datapath latches on it
//   halted     1 while in the HALT state (registered)
//   clk_stat   {halted, phm|phwb, phe|phwb}
//   icnt       retired-instruction count, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module phase_seq #(
  parameter int unsigned MEMWS = 0,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            step,
  input  logic            mem_ready,
  output logic            phf,
  output logic            phe,
  output logic            phm,
  output logic            phwb,
  output logic            en,
  output logic            halted,
  output logic [2:0]      clk_stat,
  output logic [CNTW-1:0] icnt
);

  localparam logic [3:0] MemWs = 4'(MEMWS);

  typedef enum logic [2:0] {
    StHalt,
    StFetch,
    StExec,
    StMem,
    StWb
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [3:0]      r_wc;
  logic [3:0]      w_wc_d;
  logic            r_single;
  logic            w_single_d;
  logic            r_step_q;
  logic [CNTW-1:0] r_icnt;

  logic            r_phf;
  logic            r_phe;
  logic            r_phm;
  logic            r_phwb;
  logic            r_halted;

  logic            w_step_rise;
  logic            w_mem_phase;
  logic            w_wait_done;
  logic            w_en;

  // Next-state, wait counter and single-step flag.
  always_comb begin
    w_step_rise = step & ~r_step_q;
    w_mem_phase = (r_state == StFetch) || (r_state == StMem);
    w_wait_done = (r_wc == MemWs) && mem_ready;
    w_state_d   = r_state;
    w_single_d  = r_single;

    unique case (r_state)
      StHalt: begin
        if (run) begin
          w_state_d  = StFetch;
          w_single_d = 1'b0;
        end else if (w_step_rise) begin
          w_state_d  = StFetch;
          w_single_d = 1'b1;
        end
      end
      StFetch: begin
        if (w_wait_done) w_state_d = StExec;
      end
      StExec: begin
        w_state_d = StMem;
      end
      StMem: begin
        if (w_wait_done) w_state_d = StWb;
      end
      StWb: begin
        // run is only re-sampled here; a single-step always ends in HALT.
        if (run && !r_single) w_state_d = StFetch;
        else                  w_state_d = StHalt;
      end
      default: begin
        w_state_d = StHalt;
      end
    endcase

    // wc restarts on every phase entry and saturates at MEMWS.
    if (!w_mem_phase || (w_state_d != r_state)) begin
      w_wc_d = 4'd0;
    end else if (r_wc != MemWs) begin
      w_wc_d = r_wc + 4'd1;
    end else begin
      w_wc_d = r_wc;
    end

    w_en = (w_mem_phase && w_wait_done) || (r_state == StExec) || (r_state == StWb);
  end

  // State and registered outputs; phase strobes decode the next state so
  // they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StHalt;
      r_wc     <= 4'd0;
      r_single <= 1'b0;
      r_step_q <= 1'b0;
      r_icnt   <= '0;
      r_phf    <= 1'b0;
      r_phe    <= 1'b0;
      r_phm    <= 1'b0;
      r_phwb   <= 1'b0;
      r_halted <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_wc     <= w_wc_d;
      r_single <= w_single_d;
      r_step_q <= step;
      if (r_state == StWb) begin
        r_icnt <= r_icnt + CNTW'(1);
      end
      r_phf    <= (w_state_d == StFetch);
      r_phe    <= (w_state_d == StExec);
      r_phm    <= (w_state_d == StMem);
      r_phwb   <= (w_state_d == StWb);
      r_halted <= (w_state_d == StHalt);
    end
  end

  assign phf      = r_phf;
  assign phe      = r_phe;
  assign phm      = r_phm;
  assign phwb     = r_phwb;
  assign halted   = r_halted;
  assign en       = w_en;
  assign clk_stat = {r_halted, r_phm | r_phwb, r_phe | r_phwb};
  assign icnt     = r_icnt;

endmodule

// File: tb/tb_phase_seq.sv
// ---------------------------------------------------------------------------
// tb_phase_seq: self-checking bench for phase_seq.
// u_a: MEMWS=0, CNTW=4 (wrap visible quickly). u_b: MEMWS=2, CNTW=16.
// Both share the stimulus; each sequence checks the instance it targets.
// Inputs change on the falling edge, outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_phase_seq;

  logic clk;
  logic reset;
  logic run;
  logic step;
  logic mem_ready;

  logic       a_phf, a_phe, a_phm, a_phwb, a_en, a_halted;
  logic [2:0] a_clk_stat;
  logic [3:0] a_icnt;

  logic        b_phf, b_phe, b_phm, b_phwb, b_en, b_halted;
  logic [2:0]  b_clk_stat;
  logic [15:0] b_icnt;

  int n_checks;
  int n_fail;

  phase_seq #(
    .MEMWS(0),
    .CNTW (4)
  ) u_a (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .mem_ready(mem_ready),
    .phf      (a_phf),
    .phe      (a_phe),
    .phm      (a_phm),
    .phwb     (a_phwb),
    .en       (a_en),
    .halted   (a_halted),
    .clk_stat (a_clk_stat),
    .icnt     (a_icnt)
  );

  phase_seq #(
    .MEMWS(2),
    .CNTW (16)
  ) u_b (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .step     (step),
    .mem_ready(mem_ready),
    .phf      (b_phf),
    .phe      (b_phe),
    .phm      (b_phm),
    .phwb     (b_phwb),
    .en       (b_en),
    .halted   (b_halted),
    .clk_stat (b_clk_stat),
    .icnt     (b_icnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       run;
    logic       step;
    logic       mr;
    logic       chk;
    logic [3:0] ph;     // {phf, phe, phm, phwb}
    logic       en;
    logic       halted;
    logic [3:0] icnt;
  } vec_t;

  localparam int NVec = 22;
  vec_t vecs[NVec];

  function automatic vec_t mk(input logic rst, input logic ru, input logic s, input logic m,
                              input logic c, input logic [3:0] ph, input logic e,
                              input logic h, input logic [3:0] ic);
    vec_t v;
    v.rst = rst; v.run = ru; v.step = s; v.mr = m; v.chk = c;
    v.ph = ph; v.en = e; v.halted = h; v.icnt = ic;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ru, input logic s, input logic m);
    @(negedge clk);
    reset     = r;
    run       = ru;
    step      = s;
    mem_ready = m;
    #1;
  endtask

  function automatic logic [3:0] a_ph();
    return {a_phf, a_phe, a_phm, a_phwb};
  endfunction

  function automatic logic [3:0] b_ph();
    return {b_phf, b_phe, b_phm, b_phwb};
  endfunction

  initial begin
    logic [3:0] exp_ph;
    logic       exp_en;
    int         p;
    int         wb_seen;

    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    run       = 1'b0;
    step      = 1'b0;
    mem_ready = 1'b1;

    //         rst run stp mr chk  ph       en halt icnt
    vecs[0]  = mk(1, 1, 0, 1, 0, 4'b0000, 0, 1, 4'd0);
    vecs[1]  = mk(0, 1, 0, 1, 1, 4'b0000, 0, 1, 4'd0);  // HALT after release
    vecs[2]  = mk(0, 1, 0, 1, 1, 4'b1000, 1, 0, 4'd0);  // F
    vecs[3]  = mk(0, 1, 0, 1, 1, 4'b0100, 1, 0, 4'd0);  // E
    vecs[4]  = mk(0, 1, 0, 1, 1, 4'b0010, 1, 0, 4'd0);  // M
    vecs[5]  = mk(0, 1, 0, 1, 1, 4'b0001, 1, 0, 4'd0);  // W
    vecs[6]  = mk(0, 1, 0, 0, 1, 4'b1000, 0, 0, 4'd1);  // F stalled
    vecs[7]  = mk(0, 1, 0, 0, 1, 4'b1000, 0, 0, 4'd1);
    vecs[8]  = mk(0, 1, 0, 1, 1, 4'b1000, 1, 0, 4'd1);
    vecs[9]  = mk(0, 1, 0, 1, 1, 4'b0100, 1, 0, 4'd1);
    vecs[10] = mk(0, 1, 0, 0, 1, 4'b0010, 0, 0, 4'd1);  // M stalled
    vecs[11] = mk(0, 1, 0, 1, 1, 4'b0010, 1, 0, 4'd1);
    vecs[12] = mk(0, 0, 0, 1, 1, 4'b0001, 1, 0, 4'd1);  // W, run low -> HALT
    vecs[13] = mk(0, 0, 0, 1, 1, 4'b0000, 0, 1, 4'd2);
    vecs[14] = mk(0, 0, 0, 1, 1, 4'b0000, 0, 1, 4'd2);
    vecs[15] = mk(0, 0, 1, 1, 1, 4'b0000, 0, 1, 4'd2);  // step rises
    vecs[16] = mk(0, 0, 1, 1, 1, 4'b1000, 1, 0, 4'd2);
    vecs[17] = mk(0, 0, 1, 1, 1, 4'b0100, 1, 0, 4'd2);
    vecs[18] = mk(0, 1, 1, 1, 1, 4'b0010, 1, 0, 4'd2);  // run raised mid-step
    vecs[19] = mk(0, 1, 1, 1, 1, 4'b0001, 1, 0, 4'd2);
    vecs[20] = mk(0, 1, 1, 1, 1, 4'b0000, 0, 1, 4'd3);  // step still halts
    vecs[21] = mk(0, 1, 1, 1, 1, 4'b1000, 1, 0, 4'd3);

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].rst, vecs[i].run, vecs[i].step, vecs[i].mr);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d phases", i), 32'(a_ph()), 32'(vecs[i].ph));
        check($sformatf("vec%0d en", i), 32'(a_en), 32'(vecs[i].en));
        check($sformatf("vec%0d halted", i), 32'(a_halted), 32'(vecs[i].halted));
        check($sformatf("vec%0d clk_stat", i), 32'(a_clk_stat),
              32'({vecs[i].halted, vecs[i].ph[1] | vecs[i].ph[0],
                   vecs[i].ph[2] | vecs[i].ph[0]}));
        check($sformatf("vec%0d icnt", i), 32'(a_icnt), 32'(vecs[i].icnt));
      end
    end

    // Free run: u_a 4 cycles/instr with en always 1, u_b 8 cycles/instr.
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 1);
    check("run halt_first", 32'(a_halted), 32'd1);
    for (int j = 0; j <= 68; j++) begin
      drive(0, 1, 0, 1);
      p = j % 4;
      exp_ph = 4'b1000 >> p;
      check($sformatf("run_a ph j=%0d", j), 32'(a_ph()), 32'(exp_ph));
      check($sformatf("run_a en j=%0d", j), 32'(a_en), 32'd1);
      p = j % 8;
      exp_ph = (p < 3) ? 4'b1000 : (p == 3) ? 4'b0100 : (p < 7) ? 4'b0010 : 4'b0001;
      exp_en = (p == 2) || (p == 3) || (p == 6) || (p == 7);
      check($sformatf("run_b ph j=%0d", j), 32'(b_ph()), 32'(exp_ph));
      check($sformatf("run_b en j=%0d", j), 32'(b_en), 32'(exp_en));
      if (j == 40) begin
        check("run_a icnt10", 32'(a_icnt), 32'd10);
        check("run_b icnt5", 32'(b_icnt), 32'd5);
      end
    end
    check("run_a icnt wrap", 32'(a_icnt), 32'd1);

    // F stretched by 5 cycles of mem_ready=0.
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 0);
    for (int j = 0; j < 5; j++) begin
      drive(0, 1, 0, 0);
      check($sformatf("stall phf c%0d", j), 32'(a_phf), 32'd1);
      check($sformatf("stall en c%0d", j), 32'(a_en), 32'd0);
    end
    drive(0, 1, 0, 1);
    check("stall phf last", 32'(a_phf), 32'd1);
    check("stall en last", 32'(a_en), 32'd1);
    drive(0, 1, 0, 1);
    check("stall then E", 32'(a_ph()), 32'b0100);

    // Step held high 20 cycles: exactly one instruction.
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("step idle halted", 32'(a_halted), 32'd1);
    wb_seen = 0;
    for (int j = 0; j < 20; j++) begin
      drive(0, 0, 1, 1);
      if (a_phwb) wb_seen++;
    end
    check("step one W", 32'(wb_seen), 32'd1);
    drive(0, 0, 0, 1);
    check("step halted", 32'(a_halted), 32'd1);
    check("step icnt1", 32'(a_icnt), 32'd1);
    for (int j = 0; j < 5; j++) drive(0, 0, 1, 1);
    drive(0, 0, 0, 1);
    check("step2 halted", 32'(a_halted), 32'd1);
    check("step2 icnt2", 32'(a_icnt), 32'd2);

    // run dropped during E finishes the instruction.
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 1);
    drive(0, 1, 0, 1);
    check("drop F", 32'(a_ph()), 32'b1000);
    drive(0, 0, 0, 1);
    check("drop E", 32'(a_ph()), 32'b0100);
    drive(0, 0, 0, 1);
    check("drop M", 32'(a_ph()), 32'b0010);
    drive(0, 0, 0, 1);
    check("drop W", 32'(a_ph()), 32'b0001);
    drive(0, 0, 0, 1);
    check("drop halted", 32'(a_halted), 32'd1);
    check("drop icnt", 32'(a_icnt), 32'd1);

    // Reset asserted in M.
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 1);
    for (int j = 0; j < 6; j++) drive(0, 1, 0, 1);
    drive(1, 1, 0, 1);
    check("rstm in M", 32'(a_ph()), 32'b0010);
    check("rstm icnt before", 32'(a_icnt), 32'd1);
    drive(0, 0, 0, 1);
    check("rstm halted", 32'(a_halted), 32'd1);
    check("rstm phases", 32'(a_ph()), 32'd0);
    check("rstm en", 32'(a_en), 32'd0);
    check("rstm icnt", 32'(a_icnt), 32'd0);
    check("rstm clk_stat", 32'(a_clk_stat), 32'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_seq.md
# phase_seq

Instruction-phase sequencer for the multi-cycle CPU. It steps the core through fetch, execute, memory and writeback phases. It also adds what the free-running phase ring lacks: memory wait-states, run/halt control, single-step for the debug monitor, and a retired-instruction counter. It sits between the clock/reset source, the memory bus ready line and the debug front panel, and drives the phase strobes consumed by the datapath.

## Interface

Parameters:
- MEMWS, default 0: minimum extra wait cycles inserted in F and M phases (0..15).
- CNTW, default 16: width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = free-running execution.
- step  in  1  single-step request; rising edge detected internally.
- mem_ready  in  1  memory bus ready; qualifies completion of F and M.
- phf, phe, phm, phwb  out  1 each  one-hot phase strobes; all 0 when halted.
- en  out  1  phase-complete strobe; datapath latches when en=1.
- halted  out  1  1 while in HALT state.
- clk_stat  out  3  [0]=phe|phwb, [1]=phm|phwb, [2]=halted.
- icnt  out  CNTW  retired-instruction count, wraps modulo 2^CNTW.

## Operation

- States: HALT, F, E, M, W. Phase outputs are decoded one-hot from the state.
- Reset, at any clock edge and in any state, forces: state=HALT, wait counter=0, single flag=0, step_q=0, icnt=0. Resulting outputs: phf=phe=phm=phwb=0, en=0, halted=1, clk_stat=3'b100.
- step_q registers step each cycle. step_rise = step & !step_q.
- HALT:
  - If run=1, go to F with single=0.
  - Else, if step_rise=1, go to F with single=1.
  - Otherwise stay in HALT.
- F and M:
  - Wait counter wc clears on phase entry.
  - wc increments each cycle and saturates at MEMWS.
  - The phase completes in the cycle where wc==MEMWS and mem_ready=1: en=1, then advance (F→E, M→W).
  - mem_ready=0 stretches the phase indefinitely.
- E: always exactly one cycle, en=1, then go to M.
- W:
  - Always exactly one cycle, en=1, icnt increments.
  - Next state is F if run=1 and single=0; otherwise HALT.
- run is sampled only in HALT and at the end of W.
  - Dropping run mid-instruction completes the current instruction, then halts.
  - Raising run during a single-step does not cancel the halt after that W. Execution resumes on the following HALT cycle.
- step_rise outside HALT is ignored and not queued.
- en is combinational from state, wc and mem_ready, so it is valid in the same cycle as the completing phase.
- icnt wraps from 2^CNTW−1 to 0 with no flag.

## Timing

- Reset released with run=1: the first cycle after release is HALT, and phf=1 on the next cycle.
- MEMWS=0 with mem_ready=1: 4 cycles per instruction (F,E,M,W), en=1 in every cycle.
- General instruction length: 4 + 2·MEMWS + (extra cycles with mem_ready=0 after wc reached MEMWS).
- HALT→F latency: 1 cycle from the run=1 sample or the step rising edge.
- W→HALT: halted=1 on the cycle after W.
- Back-to-back instructions have no idle cycle: W is followed directly by F.

## Test plan

- Reset, then run=1, MEMWS=0, mem_ready=1: the phase sequence after HALT is F,E,M,W repeating. After 10 W cycles, icnt=10 and en is constantly 1.
- MEMWS=2, mem_ready=1: F lasts 3 cycles and M lasts 3 cycles, giving 8 cycles per instruction. en=1 only on the third cycle of F and of M.
- MEMWS=0, mem_ready held 0 for 5 cycles during F: phf stays 1 for 6 cycles and en=0 for the first 5. E then follows.
- run=0 with step held high for 20 cycles: exactly one F,E,M,W, then halted=1 and icnt=1. A second rising edge on step gives icnt=2.
- run dropped during E: M and W complete, then HALT. run raised during single-step M: HALT for 1 cycle after W, then F.
- CNTW=4 running for 17 instructions: icnt=1. Reset asserted in M: the next cycle has halted=1, all phases 0, icnt=0 and clk_stat=3'b100.
